// File: rtl/cve2_pkg.sv
// Shared types for the cve2 memory responder.
//   mem_resp_t   : one response beat {err, rdata}
//   MemRespIdle  : value held in response stages that carry no response
package cve2_pkg;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;

  localparam mem_resp_t MemRespIdle = '{err: 1'b0, rdata: 32'h0};

endpackage

// File: rtl/cve2_mem_resp_pipe.sv
// Fixed-length delay line of {valid, mem_resp_t} with occupancy count.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset (clears valids and data)
//   in_valid_i/resp_i  stage 0 input, loaded every cycle
//   out_valid_o/resp_o last stage, straight from flops
//   count_o            number of valid stages
module cve2_mem_resp_pipe
  import cve2_pkg::*;
#(
  parameter int unsigned Depth  = 2,
  parameter int unsigned CountW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  mem_resp_t         in_resp_i,
  output logic              out_valid_o,
  output mem_resp_t         out_resp_o,
  output logic [CountW-1:0] count_o
);

  logic [Depth-1:0] valid_d, valid_q;
  mem_resp_t        resp_d [Depth];
  mem_resp_t        resp_q [Depth];

  always_comb begin
    valid_d[0] = in_valid_i;
    resp_d[0]  = in_resp_i;
    for (int i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      resp_d[i]  = resp_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) resp_q[i] <= MemRespIdle;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < Depth; i++) resp_q[i] <= resp_d[i];
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < Depth; i++) count_o = count_o + CountW'(valid_q[i]);
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_resp_o  = resp_q[Depth-1];

endmodule

// File: rtl/cve2_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid bus: word-organised storage,
// fixed-latency in-order responses, bounded outstanding requests.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   stall_i              forces gnt_o low (wait-state injection)
//   req_i, gnt_o         handshake; accept on edge with req_i & gnt_o
//   addr_i, we_i, be_i,  request fields (addr bits [1:0] ignored)
//   wdata_i
//   rvalid_o, err_o,     one response beat per accepted request
//   rdata_o
module cve2_mem_responder
  import cve2_pkg::*;
#(
  parameter int unsigned MemDepthWords  = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW      = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;
  localparam int unsigned CountW    = $clog2(RespLatency + 1);
  localparam logic [32:0] SpanBytes = 33'(MemDepthWords) << 2;

  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic            accept;
  logic            mem_we;
  logic [31:0]     mem_wr_d;
  logic [31:0]     mem_q [MemDepthWords];

  mem_resp_t       resp_in;
  mem_resp_t       resp_out;
  logic            retiring;
  logic [CountW-1:0] count;

  // 33-bit compare so a window ending at the top of the address space
  // does not wrap.
  assign offset   = addr_i - BaseAddr;
  assign in_range = (addr_i >= BaseAddr) && ({1'b0, offset} < SpanBytes);
  assign word_idx = offset[IdxW+1:2];

  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:IdxW+2], offset[1:0]};

  assign accept = req_i & gnt_o;
  assign mem_we = accept & we_i & in_range;

  always_comb begin
    mem_wr_d = mem_q[word_idx];
    for (int k = 0; k < 4; k++) begin
      if (be_i[k]) mem_wr_d[8*k +: 8] = wdata_i[8*k +: 8];
    end
  end

  // Storage is deliberately not reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[word_idx] <= mem_wr_d;
  end

  // Idle beats enter the pipe as zero so outputs read 0 whenever rvalid_o is low.
  always_comb begin
    resp_in = MemRespIdle;
    if (accept) begin
      if (!in_range)  resp_in.err   = 1'b1;
      else if (!we_i) resp_in.rdata = mem_q[word_idx];
    end
  end

  cve2_mem_resp_pipe #(
    .Depth  (RespLatency),
    .CountW (CountW)
  ) u_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (accept),
    .in_resp_i   (resp_in),
    .out_valid_o (retiring),
    .out_resp_o  (resp_out),
    .count_o     (count)
  );

  // The retiring beat frees its slot in the same cycle, so a full pipe
  // can still accept while its oldest entry leaves.
  assign gnt_o = !stall_i &&
                 ((count - CountW'(retiring)) < CountW'(MaxOutstanding));

  assign rvalid_o = retiring;
  assign err_o    = resp_out.err;
  assign rdata_o  = resp_out.rdata;

endmodule

// File: tb/tb_cve2_mem_responder.sv
module tb_cve2_mem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  err;
  logic [31:0] rdata [3];

  int          cfg_rl    [3] = '{2, 3, 3};
  int          cfg_mo    [3] = '{2, 1, 3};
  int          cfg_depth [3] = '{1024, 16, 16};
  logic [31:0] cfg_base  [3] = '{32'h0, 32'h100, 32'h100};

  exp_t        sb [3][$];
  logic [31:0] mdl [int];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  bit          accepted [3];
  int          acc_cycle [3];
  logic        last_err [3];
  logic [31:0] last_rdata [3];

  always #5 clk = ~clk;

  cve2_mem_responder u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  cve2_mem_responder #(.MemDepthWords(16), .BaseAddr(32'h100), .RespLatency(3), .MaxOutstanding(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  cve2_mem_responder #(.MemDepthWords(16), .BaseAddr(32'h100), .RespLatency(3), .MaxOutstanding(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req[2]), .gnt_o(gnt[2]),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  // Expected response for the request on the bus, pushed at acceptance.
  task automatic push(input int d);
    exp_t        e;
    longint      off;
    int          key;
    logic [31:0] w;
    off     = longint'(addr) - longint'(cfg_base[d]);
    e.due   = cycle + cfg_rl[d];
    e.err   = 1'b0;
    e.rdata = 32'h0;
    if (off < 0 || off >= 4 * cfg_depth[d]) begin
      e.err = 1'b1;
    end else begin
      key = d * 65536 + int'(off >>> 2);
      if (we) begin
        w = mdl.exists(key) ? mdl[key] : 'x;
        for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
        mdl[key] = w;
      end else begin
        e.rdata = mdl.exists(key) ? mdl[key] : 'x;
      end
    end
    sb[d].push_back(e);
  endtask

  task automatic check_responses();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rvalid[d] !== 1'b0) begin
        vectors++;
        if (sb[d].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rvalid dut%0d cycle %0d: rvalid=%b, required no response", d, cycle, rvalid[d]);
        end else begin
          e = sb[d].pop_front();
          last_err[d]   = err[d];
          last_rdata[d] = rdata[d];
          if (rvalid[d] !== 1'b1 || err[d] !== e.err || rdata[d] !== e.rdata || cycle != e.due) begin
            miscompares++;
            $display("FAIL response dut%0d: got err=%b rdata=%h at cycle %0d, required err=%b rdata=%h at cycle %0d",
                     d, err[d], rdata[d], cycle, e.err, e.rdata, e.due);
          end
        end
      end
      while (sb[d].size() > 0 && sb[d][0].due < cycle) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_response dut%0d: no rvalid by cycle %0d, required at cycle %0d", d, cycle, sb[d][0].due);
        void'(sb[d].pop_front());
      end
    end
  endtask

  // One clock: check grants against the model, record acceptances,
  // advance to the next falling edge and collect responses.
  task automatic step();
    bit exp_g;
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_g = (stall == 1'b0) && (sb[d].size() < cfg_mo[d]);
      vectors++;
      if (gnt[d] !== exp_g) begin
        miscompares++;
        $display("FAIL grant dut%0d cycle %0d: gnt=%b, required %b", d, cycle, gnt[d], exp_g);
      end
    end
    for (int d = 0; d < 3; d++) begin
      accepted[d] = 1'b0;
      if (rst_n === 1'b1 && req[d] === 1'b1 && gnt[d] === 1'b1) begin
        accepted[d]  = 1'b1;
        acc_cycle[d] = cycle + 1;
        push(d);
      end
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
    check_responses();
  endtask

  // Leaves req high so consecutive calls form a held-request burst.
  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
    addr = a; we = w; be = b; wdata = wd; req[d] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (accepted[d]) break;
    end
    if (!accepted[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout dut%0d: no acceptance of addr %h within 40 cycles, required acceptance", d, a);
    end
  endtask

  task automatic drain();
    req = '0;
    for (int n = 0; n < 20; n++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
      step();
    end
    vectors++;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses still pending, required 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; req = '0;
    addr = '0; we = 1'b0; be = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (rvalid[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0 || gnt[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: rvalid=%b err=%b rdata=%h gnt=%b, required 0 0 00000000 1",
                 d, rvalid[d], err[d], rdata[d], gnt[d]);
      end
    end
    stall = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (gnt[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stall_gnt dut%0d: gnt=%b, required 0", d, gnt[d]);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_defaults();
    int a0;
    issue(0, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF);
    a0 = acc_cycle[0];
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0);
    vectors++;
    if (acc_cycle[0] - a0 != 1) begin
      miscompares++;
      $display("FAIL default_throughput: accept gap %0d, required 1", acc_cycle[0] - a0);
    end
    drain();
    vectors++;
    if (last_err[0] !== 1'b0 || last_rdata[0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL default_readback: err=%b rdata=%h, required 0 deadbeef", last_err[0], last_rdata[0]);
    end
  endtask

  task automatic test_byte_enables();
    issue(0, 1'b1, 32'h8, 4'hF, 32'h1122_3344);
    issue(0, 1'b1, 32'h8, 4'b0101, 32'hAABB_CCDD);
    issue(0, 1'b1, 32'hC, 4'h0, 32'hFFFF_FFFF);
    issue(0, 1'b0, 32'h8, 4'h0, 32'h0);
    drain();
    vectors++;
    if (last_rdata[0] !== 32'h11BB_33DD) begin
      miscompares++;
      $display("FAIL byte_enables: rdata=%h, required 11bb33dd", last_rdata[0]);
    end
  endtask

  task automatic test_range_error();
    issue(0, 1'b0, 32'h1000, 4'h0, 32'h0);
    drain();
    vectors++;
    if (last_err[0] !== 1'b1 || last_rdata[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL range_read: err=%b rdata=%h, required 1 00000000", last_err[0], last_rdata[0]);
    end
    issue(0, 1'b1, 32'h1000, 4'hF, 32'h5555_5555);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0);
    drain();
    vectors++;
    if (last_err[0] !== 1'b0 || last_rdata[0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL range_write_isolation: err=%b rdata=%h, required 0 deadbeef", last_err[0], last_rdata[0]);
    end
    issue(1, 1'b0, 32'hFC, 4'h0, 32'h0);
    drain();
    vectors++;
    if (last_err[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL below_base: err=%b, required 1", last_err[1]);
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'h100 + 4*i, 4'hF, 32'hA000_0000 + i);
    drain();
    prev = -100;
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b0, 32'h100 + 4*i, 4'h0, 32'h0);
      vectors++;
      if (i > 0 && acc_cycle[1] - prev != 3) begin
        miscompares++;
        $display("FAIL mo1_spacing read %0d: gap %0d, required 3", i, acc_cycle[1] - prev);
      end
      prev = acc_cycle[1];
    end
    drain();
    for (int i = 0; i < 4; i++) issue(2, 1'b1, 32'h120 + 4*i, 4'hF, 32'hB000_0000 + i);
    prev = -100;
    for (int i = 0; i < 4; i++) begin
      issue(2, 1'b0, 32'h120 + 4*i, 4'h0, 32'h0);
      vectors++;
      if (i > 0 && acc_cycle[2] - prev != 1) begin
        miscompares++;
        $display("FAIL mo3_spacing read %0d: gap %0d, required 1", i, acc_cycle[2] - prev);
      end
      prev = acc_cycle[2];
    end
    drain();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) issue(0, 1'b1, 32'h40 + 4*i, 4'hF, 32'hC0DE_0000 + i);
    issue(0, 1'b0, 32'h40, 4'h0, 32'h0);
    issue(0, 1'b0, 32'h44, 4'h0, 32'h0);
    addr = 32'h48; we = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (accepted[0]) begin
        miscompares++;
        $display("FAIL stall_blocks cycle %0d: accepted=1, required 0", cycle);
      end
    end
    vectors++;
    if (sb[0].size() != 0) begin
      miscompares++;
      $display("FAIL stall_inflight: %0d responses pending, required 0", sb[0].size());
    end
    stall = 1'b0;
    step();
    vectors++;
    if (!accepted[0]) begin
      miscompares++;
      $display("FAIL stall_resume: accepted=0, required 1");
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    issue(2, 1'b1, 32'h104, 4'hF, 32'hCAFE_F00D);
    drain();
    issue(2, 1'b0, 32'h100, 4'h0, 32'h0);
    issue(2, 1'b0, 32'h104, 4'h0, 32'h0);
    req = '0;
    vectors++;
    if (sb[2].size() != 2) begin
      miscompares++;
      $display("FAIL midflight_setup: %0d pending, required 2", sb[2].size());
    end
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) sb[d].delete();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    issue(2, 1'b0, 32'h104, 4'h0, 32'h0);
    drain();
    vectors++;
    if (last_rdata[2] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL retained_after_reset: rdata=%h, required cafef00d", last_rdata[2]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    test_reset();
    test_defaults();
    test_byte_enables();
    test_range_error();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
